// File: rtl/argon_seq_ctrl.sv
// Single-issue control sequencer for the Argon regfile + ALU datapath.
// Optional build macro ARGON_SEQ_OVERLAP_EN: accept the next instruction during S_WB.
module argon_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_halt,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [17:0]           i_instr,
  input  logic [DATA_WIDTH-1:0] i_imm,
  output logic [SEL_WIDTH-1:0]  o_selectA,
  output logic [SEL_WIDTH-1:0]  o_selectB,
  output logic [SEL_WIDTH-1:0]  o_selectW,
  output logic                  o_write_en,
  output logic                  o_write_to_regfile,
  output logic                  o_use_immediate,
  output logic [DATA_WIDTH-1:0] o_portW,
  output logic [3:0]            o_alu_op,
  input  logic                  i_flag_zero,
  input  logic                  i_flag_sign,
  input  logic                  i_flag_overflow,
  input  logic                  i_flag_carry,
  output logic                  o_flag_zero,
  output logic                  o_flag_sign,
  output logic                  o_flag_overflow,
  output logic                  o_flag_carry,
  output logic                  o_busy,
  output logic [CNT_WIDTH-1:0]  o_retired
);

`ifdef ARGON_SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam logic [1:0] K_RI  = 2'b01;
  localparam logic [1:0] K_LDI = 2'b10;
  localparam logic [1:0] K_CMP = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [1:0]            kind_q, kind_d;
  logic [3:0]            op_q, op_d;
  logic [SEL_WIDTH-1:0]  rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
  logic [DATA_WIDTH-1:0] imm_q, imm_d;
  logic [3:0]            flags_q, flags_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic                  ready, accept, retire;
  state_t                accept_state;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      kind_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      imm_q     <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      imm_q     <= imm_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    op_d      = op_q;
    rd_d      = rd_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    imm_d     = imm_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    retire    = 1'b0;

    ready  = (state_q == S_IDLE) || (OVERLAP && (state_q == S_WB) && !i_halt);
    accept = ready && i_instr_valid && !i_halt;
    // LDI skips the ALU entirely and writes on the very next cycle
    accept_state = (i_instr[17:16] == K_LDI) ? S_WB : S_EXEC;

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = accept_state;
      end
      S_EXEC: begin
        if (!i_halt) begin
          flags_d = {i_flag_zero, i_flag_sign, i_flag_overflow, i_flag_carry};
          if (kind_q == K_CMP) begin
            retire  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (!i_halt) begin
          retire  = 1'b1;
          state_d = accept ? accept_state : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      kind_d = i_instr[17:16];
      op_d   = i_instr[15:12];
      rd_d   = SEL_WIDTH'(i_instr[11:8]);
      ra_d   = SEL_WIDTH'(i_instr[7:4]);
      rb_d   = SEL_WIDTH'(i_instr[3:0]);
      imm_d  = i_imm;
    end

    if (retire) retired_d = retired_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end

  // Outputs decode only flops; halt is the one live gate, on the write strobe/ready
  assign o_instr_ready      = ready;
  assign o_busy             = (state_q != S_IDLE);
  assign o_selectA          = o_busy ? ra_q : '0;
  assign o_selectB          = o_busy ? rb_q : '0;
  assign o_alu_op           = o_busy ? op_q : 4'd0;
  assign o_use_immediate    = o_busy && (kind_q == K_RI);
  assign o_selectW          = (state_q == S_WB) ? rd_q : '0;
  assign o_write_en         = (state_q == S_WB) && !i_halt;
  assign o_write_to_regfile = (state_q == S_WB) && (kind_q == K_LDI);
  assign o_portW            = imm_q;
  assign o_flag_zero        = flags_q[3];
  assign o_flag_sign        = flags_q[2];
  assign o_flag_overflow    = flags_q[1];
  assign o_flag_carry       = flags_q[0];
  assign o_retired          = retired_q;

endmodule

// File: tb/tb_argon_seq_ctrl.sv
// Directed bench for argon_seq_ctrl; expectations are hand-computed per step.
module tb_argon_seq_ctrl;

`ifdef ARGON_SEQ_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [17:0] instr = '0;
  logic [15:0] imm_in = '0;
  logic [3:0]  sel_a, sel_b, sel_w, alu_op;
  logic        we, wtr, use_imm, busy;
  logic [15:0] port_w, retired;
  logic        fz_i = 1'b0, fs_i = 1'b0, fo_i = 1'b0, fc_i = 1'b0;
  logic        fz, fs, fo, fc;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  argon_seq_ctrl dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_halt(halt),
    .i_instr_valid(valid), .o_instr_ready(ready), .i_instr(instr), .i_imm(imm_in),
    .o_selectA(sel_a), .o_selectB(sel_b), .o_selectW(sel_w),
    .o_write_en(we), .o_write_to_regfile(wtr), .o_use_immediate(use_imm),
    .o_portW(port_w), .o_alu_op(alu_op),
    .i_flag_zero(fz_i), .i_flag_sign(fs_i), .i_flag_overflow(fo_i), .i_flag_carry(fc_i),
    .o_flag_zero(fz), .o_flag_sign(fs), .o_flag_overflow(fo), .o_flag_carry(fc),
    .o_busy(busy), .o_retired(retired)
  );

  function automatic logic [17:0] mk(input logic [1:0] k, input logic [3:0] op,
                                     input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb);
    return {k, op, rd, ra, rb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("tag=%s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one instruction for exactly one edge; returns at the negedge after it
  task automatic issue(input logic [17:0] ins, input logic [15:0] imm);
    @(negedge clk);
    instr = ins; imm_in = imm; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    $display("issue instr=0x%05h imm=0x%04h retired=%0d", ins, imm, retired);
  endtask

  logic [15:0] base;
  int          n;

  initial begin
    // reset state
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", we, 0);
    chk("rst_retired", retired, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: LDI r1=5, LDI r2=3
    issue(mk(2'b10, 4'd0, 4'd1, 4'd0, 4'd0), 16'h0005);
    chk("ldi1_we", we, 1);
    chk("ldi1_selw", sel_w, 1);
    chk("ldi1_wtr", wtr, 1);
    chk("ldi1_portw", port_w, 16'h0005);
    chk("ldi1_ready_wb", ready, OVL);
    @(negedge clk);
    chk("ldi1_we_off", we, 0);
    chk("ldi1_selw_off", sel_w, 0);
    issue(mk(2'b10, 4'd0, 4'd2, 4'd0, 4'd0), 16'h0003);
    chk("ldi2_selw", sel_w, 2);
    chk("ldi2_portw", port_w, 16'h0003);
    @(negedge clk);
    chk("ldi_retired", retired, 2);

    // 2: ADD r3 = r1 + r2, then ri op with carry flag
    issue(mk(2'b00, 4'd0, 4'd3, 4'd1, 4'd2), 16'h00AA);
    instr = mk(2'b10, 4'd9, 4'd9, 4'd9, 4'd9); imm_in = 16'h5555;
    chk("add_exec_we", we, 0);
    chk("add_exec_sela", sel_a, 1);
    chk("add_exec_selb", sel_b, 2);
    chk("add_exec_useimm", use_imm, 0);
    chk("add_exec_selw", sel_w, 0);
    @(negedge clk);
    chk("add_wb_we", we, 1);
    chk("add_wb_selw", sel_w, 3);
    chk("add_wb_wtr", wtr, 0);
    chk("add_ignore_instr", port_w, 16'h00AA);
    @(negedge clk);
    chk("add_retired", retired, 3);
    chk("add_we_off", we, 0);
    fc_i = 1'b1;
    issue(mk(2'b01, 4'd3, 4'd4, 4'd1, 4'd0), 16'h0007);
    chk("ri_exec_useimm", use_imm, 1);
    chk("ri_exec_op", alu_op, 3);
    chk("ri_exec_portw", port_w, 16'h0007);
    @(negedge clk);
    fc_i = 1'b0;
    chk("ri_wb_useimm", use_imm, 1);
    chk("ri_wb_op", alu_op, 3);
    chk("ri_flag_carry", fc, 1);
    @(negedge clk);
    chk("ri_retired", retired, 4);

    // 3: CMP r1,r1 with zero flag; then LDI must leave flags alone
    fz_i = 1'b1;
    issue(mk(2'b11, 4'd1, 4'd0, 4'd1, 4'd1), 16'h0000);
    chk("cmp_exec_we", we, 0);
    chk("cmp_exec_fz_old", fz, 0);
    @(negedge clk);
    chk("cmp_fz", fz, 1);
    chk("cmp_fc_cleared", fc, 0);
    chk("cmp_we", we, 0);
    chk("cmp_busy", busy, 0);
    chk("cmp_retired", retired, 5);
    fz_i = 1'b0; fs_i = 1'b1;
    issue(mk(2'b10, 4'd0, 4'd6, 4'd0, 4'd0), 16'h0011);
    @(negedge clk);
    chk("ldi_keeps_fz", fz, 1);
    chk("ldi_keeps_fs", fs, 0);
    chk("ldi_retired", retired, 6);
    fs_i = 1'b0;

    // 4: halt during S_WB
    issue(mk(2'b00, 4'd2, 4'd5, 4'd1, 4'd2), 16'h0000);
    @(negedge clk);
    chk("halt_pre_we", we, 1);
    halt = 1'b1; #1;
    chk("halt_we_forced", we, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("halt_we_%0d", i), we, 0);
      chk($sformatf("halt_selw_%0d", i), sel_w, 5);
      chk($sformatf("halt_ret_%0d", i), retired, 6);
    end
    halt = 1'b0; #1;
    chk("halt_release_we", we, 1);
    @(negedge clk);
    chk("halt_retired", retired, 7);
    chk("halt_we_off", we, 0);

    // 5: reset during S_EXEC
    issue(mk(2'b00, 4'd0, 4'd6, 4'd1, 4'd2), 16'h0000);
    chk("rstx_busy_before", busy, 1);
    rst_n = 1'b0; #1;
    chk("rstx_ready", ready, 1);
    chk("rstx_busy", busy, 0);
    chk("rstx_sela", sel_a, 0);
    chk("rstx_fz", fz, 0);
    chk("rstx_retired", retired, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rstx_we", we, 0);
    chk("rstx_busy_after", busy, 0);

    // 6: counter wrap
    force dut.retired_q = 16'hFFEF;
    #1 release dut.retired_q;
    for (int i = 0; i < 16; i++) begin
      issue(mk(2'b10, 4'd0, 4'd1, 4'd0, 4'd0), 16'(i));
      @(negedge clk);
    end
    chk("wrap_ffff", retired, 16'hFFFF);
    issue(mk(2'b10, 4'd0, 4'd1, 4'd0, 4'd0), 16'h0000);
    @(negedge clk);
    chk("wrap_zero", retired, 16'h0000);

    // Steady-state throughput: edges between 1st and 5th retire of back-to-back ALU ops
    base = retired;
    @(negedge clk);
    instr = mk(2'b00, 4'd0, 4'd7, 4'd1, 4'd2); valid = 1'b1;
    n = 0;
    while (retired != base + 16'd1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    n = 0;
    while (retired != base + 16'd5 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    $display("throughput: 4 ALU ops in %0d cycles", n);
    chk("thruput", n, OVL ? 8 : 12);
    valid = 1'b0;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk); n++;
    end
    chk("drain_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
